// File: rtl/vedic_pkg.sv
// Shared definitions for the pipelined Vedic multiplier: pipeline depth,
// sign-magnitude helpers and the default-configuration stage payload.
package vedic_pkg;

    localparam int VEDIC_LAT   = 3;
    localparam int VEDIC_WIDTH = 16;
    localparam int VEDIC_TAG_W = 4;

    // Helpers work at a fixed maximum width; callers extend on the way in
    // and size-cast on the way out, so one function serves every WIDTH < 64.
    localparam int VEDIC_MAX_W = 64;
    localparam int VEDIC_P_W   = 2 * VEDIC_MAX_W;

    // Stage-0 payload for the default configuration.
    typedef struct packed {
        logic [VEDIC_WIDTH-1:0] a;
        logic [VEDIC_WIDTH-1:0] b;
        logic                   neg;
        logic [VEDIC_TAG_W-1:0] tag;
    } vedic_payload_t;

    // Magnitude of x. When sgn is set the caller must have sign-extended x,
    // so the top bit is the operand's sign. The most negative operand maps to
    // 2^(W-1), which still fits in W unsigned bits once truncated.
    function automatic logic [VEDIC_MAX_W-1:0] vedic_abs(
        input logic [VEDIC_MAX_W-1:0] x,
        input logic                   sgn
    );
        return (sgn && x[VEDIC_MAX_W-1]) ? (~x + VEDIC_MAX_W'(1)) : x;
    endfunction

    // Two's-complement negation of an unsigned product when en is set.
    // Truncating the result afterwards stays correct modulo 2^(2W).
    function automatic logic [VEDIC_P_W-1:0] vedic_neg(
        input logic [VEDIC_P_W-1:0] p,
        input logic                 en
    );
        return en ? (~p + VEDIC_P_W'(1)) : p;
    endfunction

endpackage

// File: rtl/vedic_core.sv
// Combinational unsigned NxN Vedic (Urdhva-Tiryagbhyam) multiplier.
// Splits recursively into four (N/2)x(N/2) quadrant products down to a
// 2x2 leaf built from AND gates and two half adders, then shift-adds.
module vedic_core #(
    parameter int N = 8
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    generate
        if (N == 2) begin : g_leaf
            logic pp00, pp01, pp10, pp11;
            logic s1, c1, s2, c2;

            assign pp00 = a[0] & b[0];
            assign pp01 = a[0] & b[1];
            assign pp10 = a[1] & b[0];
            assign pp11 = a[1] & b[1];

            // Cross terms meet in the first half adder, its carry joins a1*b1.
            assign s1 = pp10 ^ pp01;
            assign c1 = pp10 & pp01;
            assign s2 = pp11 ^ c1;
            assign c2 = pp11 & c1;

            assign p = {c2, s2, s1, pp00};
        end else begin : g_split
            localparam int H = N / 2;

            logic [N-1:0]   ll, lh, hl, hh;
            logic [2*N-1:0] mid;

            vedic_core #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
            vedic_core #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(lh));
            vedic_core #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(hl));
            vedic_core #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(hh));

            // Cross products share the same weight, so they are summed first.
            assign mid = {{N{1'b0}}, lh} + {{N{1'b0}}, hl};
            assign p   = {{N{1'b0}}, ll} + (mid << H) + {hh, {N{1'b0}}};
        end
    endgenerate

endmodule

// File: rtl/vedic_mul_pipe.sv
// Three-stage pipelined WIDTH x WIDTH Vedic multiplier with signed/unsigned
// mode per beat, pass-through tag and valid/ready handshake with backpressure.
// S0 takes magnitudes, S1 forms quadrant products, S2 combines and re-signs.
module vedic_mul_pipe
    import vedic_pkg::*;
#(
    parameter int WIDTH = VEDIC_WIDTH,
    parameter int TAG_W = VEDIC_TAG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);

    localparam int H = WIDTH / 2;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             neg;
        logic [TAG_W-1:0] tag;
    } s0_t;

    logic v0, v1, v2;
    logic en0, en1, en2;

    s0_t              s0_d, s0_q;
    logic [WIDTH-1:0] ll_d, lh_d, hl_d, hh_d;
    logic [WIDTH-1:0] ll_q, lh_q, hl_q, hh_q;
    logic             neg1_q;
    logic [TAG_W-1:0] tag1_q;
    logic [2*WIDTH-1:0] sum_d, prod_d;

    // A stage may load when it is empty or the stage after it moves; empty
    // slots therefore fill even under stall, compressing bubbles.
    assign en2       = ~v2 | out_ready;
    assign en1       = ~v1 | en2;
    assign en0       = ~v0 | en1;
    assign in_ready  = en0;
    assign out_valid = v2;
    assign busy      = v0 | v1 | v2;

    // Operand magnitudes and result sign for the incoming beat.
    always_comb begin
        s0_d     = '0;
        s0_d.a   = WIDTH'(vedic_abs({{(VEDIC_MAX_W-WIDTH){in_signed & in_a[WIDTH-1]}}, in_a}, in_signed));
        s0_d.b   = WIDTH'(vedic_abs({{(VEDIC_MAX_W-WIDTH){in_signed & in_b[WIDTH-1]}}, in_b}, in_signed));
        s0_d.neg = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
        s0_d.tag = in_tag;
    end

    // Stage 0 register: captures the beat whenever the stage may load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0   <= 1'b0;
            s0_q <= '0;
        end else if (en0) begin
            v0   <= in_valid;
            s0_q <= s0_d;
        end
    end

    vedic_core #(.N(H)) u_ll (.a(s0_q.a[H-1:0]),     .b(s0_q.b[H-1:0]),     .p(ll_d));
    vedic_core #(.N(H)) u_lh (.a(s0_q.a[H-1:0]),     .b(s0_q.b[WIDTH-1:H]), .p(lh_d));
    vedic_core #(.N(H)) u_hl (.a(s0_q.a[WIDTH-1:H]), .b(s0_q.b[H-1:0]),     .p(hl_d));
    vedic_core #(.N(H)) u_hh (.a(s0_q.a[WIDTH-1:H]), .b(s0_q.b[WIDTH-1:H]), .p(hh_d));

    // Stage 1 register: quadrant partial products plus sign and tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1     <= 1'b0;
            ll_q   <= '0;
            lh_q   <= '0;
            hl_q   <= '0;
            hh_q   <= '0;
            neg1_q <= 1'b0;
            tag1_q <= '0;
        end else if (en1) begin
            v1     <= v0;
            ll_q   <= ll_d;
            lh_q   <= lh_d;
            hl_q   <= hl_d;
            hh_q   <= hh_d;
            neg1_q <= s0_q.neg;
            tag1_q <= s0_q.tag;
        end
    end

    // Shift-add of the quadrants, then two's-complement if the signs differed.
    always_comb begin
        sum_d  = {{WIDTH{1'b0}}, ll_q}
               + (({{WIDTH{1'b0}}, lh_q} + {{WIDTH{1'b0}}, hl_q}) << H)
               + {hh_q, {WIDTH{1'b0}}};
        prod_d = (2*WIDTH)'(vedic_neg(VEDIC_P_W'(sum_d), neg1_q));
    end

    // Stage 2 register: holds the result steady until downstream takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2       <= 1'b0;
            out_prod <= '0;
            out_tag  <= '0;
        end else if (en2) begin
            v2       <= v1;
            out_prod <= prod_d;
            out_tag  <= tag1_q;
        end
    end

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Self-checking bench for vedic_mul_pipe (WIDTH=16, TAG_W=4): directed
// vectors with hand-computed products, stall/drain, mid-stream reset and a
// randomised run against a scoreboard built from a plain a*b model.
module tb_vedic_mul_pipe;

    localparam int WIDTH = 16;
    localparam int TAG_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               in_signed;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_prod;
    logic [TAG_W-1:0]   out_tag;
    logic               busy;

    int vecCount = 0;
    int errCount = 0;

    typedef struct {
        logic [2*WIDTH-1:0] prod;
        logic [TAG_W-1:0]   tag;
    } exp_t;

    exp_t expQ[$];

    vedic_mul_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference product straight from the arithmetic definition.
    function automatic logic [31:0] modelProd(input logic [15:0] a, input logic [15:0] b, input logic sgn);
        logic signed [31:0] sa, sb;
        if (sgn) begin
            sa = {{16{a[15]}}, a};
            sb = {{16{b[15]}}, b};
            return sa * sb;
        end
        return {16'h0000, a} * {16'h0000, b};
    endfunction

    function automatic logic [15:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'hFFFF;
            2:       return 16'h0000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Scoreboard: sampled mid-cycle, so both handshakes seen here fire on
    // the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0) begin
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("sb_unexpected_beat", 32'(out_tag), 32'hFFFF_FFFF);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sb_prod", out_prod, e.prod);
                    checkOutput("sb_tag", 32'(out_tag), 32'(e.tag));
                end
            end
            if (in_valid && in_ready) begin
                e.prod = modelProd(in_a, in_b, in_signed);
                e.tag  = in_tag;
                expQ.push_back(e);
            end
        end
    end

    // Present one beat and hold it until it is accepted; returns 1ns after
    // the accepting edge with in_valid dropped.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic sgn, input logic [3:0] tag);
        int n;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = sgn;
        in_tag    = tag;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) checkOutput("accept_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // One isolated beat: result must appear on the 3rd edge counting the accept edge.
    task automatic runDirected(input string name, input logic [15:0] a, input logic [15:0] b,
                               input logic sgn, input logic [3:0] tag, input logic [31:0] expProd);
        applyStimulus(a, b, sgn, tag);
        @(posedge clk); #1;
        checkOutput({name, "_early"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({name, "_prod"}, out_prod, expProd);
        checkOutput({name, "_tag"}, 32'(out_tag), 32'(tag));
        @(posedge clk); #1;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while ((busy || expQ.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({name, "_drained"}, 32'(expQ.size()), 32'd0);
        checkOutput({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit   hist[14];
        int   first, last, ones, acc, k, sent, cyc;
        logic fire;

        rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_signed = 1'b0; in_tag = '0; out_ready = 1'b1;

        // Reset state
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_out_prod", out_prod, 32'd0);
        checkOutput("rst_out_tag", 32'(out_tag), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed unsigned and signed corner products
        runDirected("u_ffff_sq", 16'hFFFF, 16'hFFFF, 1'b0, 4'd3, 32'hFFFE_0001);
        runDirected("s_min_sq", 16'h8000, 16'h8000, 1'b1, 4'd5, 32'h4000_0000);
        runDirected("s_min_x1", 16'h8000, 16'h0001, 1'b1, 4'd6, 32'hFFFF_8000);
        runDirected("s_m1_sq", 16'hFFFF, 16'hFFFF, 1'b1, 4'd7, 32'h0000_0001);
        runDirected("u_min_x1", 16'h8000, 16'h0001, 1'b0, 4'd9, 32'h0000_8000);
        waitIdle("directed");

        // Back-to-back beats: expect one unbroken run of 8 valid cycles
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_signed = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (i < 8) begin
                in_a   = 16'(i);
                in_b   = 16'(i + 1);
                in_tag = 4'(i);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            hist[i] = out_valid;
        end
        first = -1; last = -1; ones = 0;
        for (int i = 0; i < 14; i++) begin
            if (hist[i]) begin
                if (first < 0) first = i;
                last = i;
                ones++;
            end
        end
        checkOutput("b2b_first_valid", 32'(first), 32'd2);
        checkOutput("b2b_valid_count", 32'(ones), 32'd8);
        checkOutput("b2b_contiguous", 32'(last - first + 1), 32'd8);
        waitIdle("b2b");

        // Backpressure: only three beats fit, the head result is held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_signed = 1'b0;
        k = 0; acc = 0;
        in_a = 16'd3; in_b = 16'd5; in_tag = 4'd8;
        for (int c = 0; c < 6; c++) begin
            #1;
            fire = in_ready;
            if (fire) acc++;
            @(posedge clk); #1;
            if (fire) begin
                k++;
                in_a = 16'(3 + k); in_b = 16'd5; in_tag = 4'(8 + k);
            end
            if (out_valid) begin
                checkOutput("stall_hold_prod", out_prod, 32'h0000_000F);
                checkOutput("stall_hold_tag", 32'(out_tag), 32'd8);
            end
        end
        checkOutput("stall_accepts", 32'(acc), 32'd3);
        checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waitIdle("stall");

        // Reset with two beats in flight drops them immediately
        in_valid = 1'b1; in_signed = 1'b0;
        in_a = 16'd100; in_b = 16'd200; in_tag = 4'd1;
        @(posedge clk); #1;
        in_a = 16'd300; in_b = 16'd400; in_tag = 4'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("midrst_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        expQ.delete();
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_out_prod", out_prod, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        runDirected("post_rst", 16'hFFFE, 16'h0003, 1'b1, 4'd12, 32'hFFFF_FFFA);
        waitIdle("post_rst");

        // Randomised traffic with random backpressure
        sent = 0; cyc = 0; fire = 1'b0;
        in_valid = 1'b0;
        while (sent < 10000 && cyc < 60000) begin
            if (!in_valid || fire) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_a      = pickOperand();
                in_b      = pickOperand();
                in_signed = 1'($urandom_range(0, 1));
                in_tag    = 4'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            fire = in_valid && in_ready;
            if (fire) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("rand_sent", 32'(sent), 32'd10000);
        waitIdle("rand");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
